// File: rtl/regfile_pkg.sv
// Shared definitions for the per-block register-file write controller.
// Holds the address-width helper, controller state encoding and field-select constants.
package regfile_pkg;

  // Width of an index into n entries; never narrower than one bit.
  function automatic int addr_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ADDR_W_DEFAULT = addr_w_f(256);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_ISSUE   = 3'd1,
    WR_WAIT1   = 3'd2,
    WR_WAIT2   = 3'd3,
    SYNC_START = 3'd4,
    SYNC_RUN   = 3'd5
  } ctrl_state_e;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

endpackage

// File: rtl/regfile_req_arbiter.sv
// Combinational winner pick for the shared regfile write port.
// Fixed priority (lowest index) by default; REGFILE_CTRL_ROUND_ROBIN_EN starts the search at rr_ptr.
module regfile_req_arbiter
  import regfile_pkg::*;
#(
  parameter  int n_req = 4,
  localparam int idx_w = addr_w_f(n_req)
) (
  input  logic [n_req-1:0] req,
`ifdef REGFILE_CTRL_ROUND_ROBIN_EN
  input  logic [idx_w-1:0] rr_ptr,
`endif
  output logic             valid,
  output logic [idx_w-1:0] winner,
  output logic [n_req-1:0] grant
);

  logic [idx_w-1:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    grant  = '0;
    idx    = '0;
    for (int k = 0; k < n_req; k++) begin
`ifdef REGFILE_CTRL_ROUND_ROBIN_EN
      idx = idx_w'((int'(rr_ptr) + k) % n_req);
`else
      idx = idx_w'(k);
`endif
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
    if (valid) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/block_regfile_ctrl.sv
// Write-port arbiter and sync sequencer for the per-block register file.
// Optional build macro: REGFILE_CTRL_ROUND_ROBIN_EN selects round-robin arbitration.
module block_regfile_ctrl
  import regfile_pkg::*;
#(
  parameter  int data_width   = 16,
  parameter  int n_blocks     = 256,
  parameter  int n_req        = 4,
  parameter  int sync_timeout = 8,
  localparam int addr_w       = addr_w_f(n_blocks),
  localparam int idx_w        = addr_w_f(n_req),
  localparam int cnt_w        = addr_w_f(sync_timeout)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [addr_w-1:0]           n_active_blocks,
  input  logic [n_req-1:0]            req,
  input  logic [n_req*addr_w-1:0]     req_addr,
  input  logic [n_req*data_width-1:0] req_value,
  input  logic [n_req-1:0]            req_select,
  output logic [n_req-1:0]            ack,
  input  logic                        sync_req,
  output logic                        sync_done,
  output logic                        sync_error,
  output logic [addr_w-1:0]           rf_write_addr,
  output logic [data_width-1:0]       rf_write_value,
  output logic                        rf_write_select,
  output logic                        rf_write_enable,
  output logic                        rf_sync,
  input  logic                        rf_syncing,
  output logic                        busy
);

  ctrl_state_e             state_q, state_d;
  logic                    sync_pend_q, sync_pend_d;
  logic                    seen_rise_q, seen_rise_d;
  logic                    sync_error_d;
  logic [cnt_w-1:0]        cnt_q, cnt_d;
  logic                    we_d, sync_d, done_d, load;
  logic [n_req-1:0]        ack_d, grant, grant_q;
  logic                    arb_valid;
  logic [idx_w-1:0]        winner;
  logic [addr_w-1:0]       wr_addr_q;
  logic [data_width-1:0]   wr_value_q;
  logic                    wr_sel_q;
`ifdef REGFILE_CTRL_ROUND_ROBIN_EN
  logic [idx_w-1:0]        rr_ptr, winner_q;
`endif

  regfile_req_arbiter #(.n_req(n_req)) u_arb (
    .req    (req),
`ifdef REGFILE_CTRL_ROUND_ROBIN_EN
    .rr_ptr (rr_ptr),
`endif
    .valid  (arb_valid),
    .winner (winner),
    .grant  (grant)
  );

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    sync_pend_d  = sync_pend_q;
    seen_rise_d  = seen_rise_q;
    cnt_d        = cnt_q;
    sync_error_d = sync_error;
    we_d         = 1'b0;
    sync_d       = 1'b0;
    done_d       = 1'b0;
    ack_d        = '0;
    load         = 1'b0;
    // A request arriving while a sweep is already under way merges into it.
    if (sync_req && state_q != SYNC_START && state_q != SYNC_RUN) sync_pend_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (sync_pend_q || sync_req) begin
          state_d = SYNC_START;
        end else if (arb_valid) begin
          load    = 1'b1;
          state_d = WR_ISSUE;
        end
      end
      WR_ISSUE: begin
        we_d    = 1'b1;
        ack_d   = grant_q;
        state_d = WR_WAIT1;
      end
      WR_WAIT1: state_d = WR_WAIT2;
      WR_WAIT2: state_d = IDLE;
      SYNC_START: begin
        seen_rise_d = 1'b0;
        cnt_d       = '0;
        if (n_active_blocks == '0) begin
          done_d      = 1'b1;
          sync_pend_d = 1'b0;
          state_d     = IDLE;
        end else begin
          sync_d  = 1'b1;
          state_d = SYNC_RUN;
        end
      end
      SYNC_RUN: begin
        if (!seen_rise_q) begin
          if (rf_syncing) begin
            seen_rise_d = 1'b1;
          end else if (cnt_q == cnt_w'(sync_timeout - 1)) begin
            sync_error_d = 1'b1;
            done_d       = 1'b1;
            sync_pend_d  = 1'b0;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (!rf_syncing) begin
          done_d      = 1'b1;
          sync_pend_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Captured write payload; always loaded before it is used, so no reset needed.
  always_ff @(posedge clk) begin
    if (load) begin
      wr_addr_q  <= req_addr[int'(winner)*addr_w +: addr_w];
      wr_value_q <= req_value[int'(winner)*data_width +: data_width];
      wr_sel_q   <= req_select[winner];
      grant_q    <= grant;
`ifdef REGFILE_CTRL_ROUND_ROBIN_EN
      winner_q   <= winner;
`endif
    end
  end

  // Outputs are registered, so each strobe appears the cycle after its decoding state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      sync_pend_q     <= 1'b0;
      seen_rise_q     <= 1'b0;
      cnt_q           <= '0;
      sync_error      <= 1'b0;
      sync_done       <= 1'b0;
      ack             <= '0;
      rf_write_enable <= 1'b0;
      rf_sync         <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_value  <= '0;
      rf_write_select <= 1'b0;
`ifdef REGFILE_CTRL_ROUND_ROBIN_EN
      rr_ptr          <= '0;
`endif
    end else begin
      state_q         <= state_d;
      sync_pend_q     <= sync_pend_d;
      seen_rise_q     <= seen_rise_d;
      cnt_q           <= cnt_d;
      sync_error      <= sync_error_d;
      sync_done       <= done_d;
      ack             <= ack_d;
      rf_write_enable <= we_d;
      rf_sync         <= sync_d;
      if (we_d) begin
        rf_write_addr   <= wr_addr_q;
        rf_write_value  <= wr_value_q;
        rf_write_select <= wr_sel_q;
      end
`ifdef REGFILE_CTRL_ROUND_ROBIN_EN
      if (we_d) rr_ptr <= (winner_q == idx_w'(n_req - 1)) ? '0 : winner_q + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_block_regfile_ctrl.sv
// Self-checking bench for block_regfile_ctrl with a behavioural arbitration model and a regfile sync stub.
`timescale 1ns/1ps
module tb_block_regfile_ctrl;
  import regfile_pkg::*;

  localparam int DW = 16, NB = 256, NR = 4, TO = 8;
  localparam int AW = addr_w_f(NB);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [AW-1:0]     n_active_blocks = AW'(16);
  logic [NR-1:0]     req = '0;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_value;
  logic [NR-1:0]     req_select = '0;
  logic [NR-1:0]     ack;
  logic              sync_req = 1'b0;
  logic              sync_done, sync_error;
  logic [AW-1:0]     rf_write_addr;
  logic [DW-1:0]     rf_write_value;
  logic              rf_write_select, rf_write_enable, rf_sync, busy;
  logic              rf_syncing = 1'b0;

  logic [AW-1:0] addr_t [NR];
  logic [DW-1:0] val_t  [NR];

  int n_checks = 0, n_fails = 0;
  int sync_pulses = 0, done_pulses = 0;
  int model_ptr = 0;
  bit stub_dead = 1'b0;
  int stub_len = 4;

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_value = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = addr_t[i];
      req_value[i*DW +: DW] = val_t[i];
    end
  end

  block_regfile_ctrl #(.data_width(DW), .n_blocks(NB), .n_req(NR), .sync_timeout(TO)) dut (
    .clk(clk), .reset(reset), .n_active_blocks(n_active_blocks),
    .req(req), .req_addr(req_addr), .req_value(req_value), .req_select(req_select),
    .ack(ack), .sync_req(sync_req), .sync_done(sync_done), .sync_error(sync_error),
    .rf_write_addr(rf_write_addr), .rf_write_value(rf_write_value),
    .rf_write_select(rf_write_select), .rf_write_enable(rf_write_enable),
    .rf_sync(rf_sync), .rf_syncing(rf_syncing), .busy(busy)
  );

  // Regfile stub: syncing rises two cycles after rf_sync and holds stub_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (rf_sync && !stub_dead) begin
        repeat (2) @(negedge clk);
        rf_syncing = 1'b1;
        repeat (stub_len) @(negedge clk);
        rf_syncing = 1'b0;
      end
    end
  end

  // Port-level invariants checked every cycle outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rf_sync) sync_pulses++;
        if (sync_done) done_pulses++;
        n_checks++;
        if ((rf_write_enable && (rf_sync || rf_syncing)) !== 1'b0) begin
          n_fails++;
          $display("FAIL wr_sync_overlap: we=%b rf_sync=%b rf_syncing=%b, required no overlap",
                   rf_write_enable, rf_sync, rf_syncing);
        end
        n_checks++;
        if (((ack != '0) !== rf_write_enable) || !$onehot0(ack)) begin
          n_fails++;
          $display("FAIL ack_vs_we: ack=%b we=%b, required one-hot ack exactly with we", ack, rf_write_enable);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected winner from the pending set: lowest index, or first at/after model_ptr under round-robin.
  function automatic int model_pick(input logic [NR-1:0] pend);
    int i;
    for (int k = 0; k < NR; k++) begin
`ifdef REGFILE_CTRL_ROUND_ROBIN_EN
      i = (model_ptr + k) % NR;
`else
      i = k;
`endif
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    req = '0;
    sync_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ack, sync_done, sync_error, rf_write_enable, rf_sync, busy} !== '0) begin
      n_fails++;
      $display("FAIL reset_ctrl: ack=%b done=%b err=%b we=%b sync=%b busy=%b, required all 0",
               ack, sync_done, sync_error, rf_write_enable, rf_sync, busy);
    end
    n_checks++;
    if ({rf_write_addr, rf_write_value, rf_write_select} !== '0) begin
      n_fails++;
      $display("FAIL reset_data: addr=%h value=%h sel=%b, required 0", rf_write_addr, rf_write_value, rf_write_select);
    end
    reset = 1'b0;
    model_ptr = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || ack !== '0) begin
      n_fails++;
      $display("FAIL reset_release_idle: busy=%b ack=%b, required 0 with no requests", busy, ack);
    end
  endtask

  task automatic test_single_write();
    int waited = 0;
    addr_t[2] = AW'(5);
    val_t[2] = 16'h1234;
    req_select[2] = SEL_HI;
    req[2] = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (ack == '0 && waited < 10);
    n_checks++;
    if (waited !== 2) begin
      n_fails++;
      $display("FAIL single_latency: ack after %0d cycles, required 2", waited);
    end
    n_checks++;
    if (ack !== 4'b0100 || rf_write_enable !== 1'b1) begin
      n_fails++;
      $display("FAIL single_ack: ack=%b we=%b, required 0100 with we=1", ack, rf_write_enable);
    end
    n_checks++;
    if (rf_write_addr !== AW'(5) || rf_write_value !== 16'h1234 || rf_write_select !== SEL_HI) begin
      n_fails++;
      $display("FAIL single_payload: addr=%0d value=%h sel=%b, required 5 1234 1",
               rf_write_addr, rf_write_value, rf_write_select);
    end
    req[2] = 1'b0;
    model_ptr = 3;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || ack !== '0) begin
      n_fails++;
      $display("FAIL single_return_idle: busy=%b ack=%b, required 0", busy, ack);
    end
  endtask

  task automatic test_arbitration(input int rounds);
    for (int r = 0; r < rounds; r++) begin
      logic [NR-1:0] pend;
      int w, last, waited;
      pend = NR'($urandom_range(1, (1 << NR) - 1));
      if (r == 0) pend = '1;
      for (int i = 0; i < NR; i++) begin
        addr_t[i] = AW'($urandom);
        val_t[i] = DW'($urandom);
        req_select[i] = 1'($urandom);
      end
      req = pend;
      last = -1;
      waited = 0;
      while (pend != '0 && waited < 40) begin
        @(negedge clk);
        waited++;
        if (ack != '0) begin
          w = model_pick(pend);
          n_checks++;
          if (w < 0 || ack !== (NR'(1) << w)) begin
            n_fails++;
            $display("FAIL arb_grant: ack=%b pending=%b required winner %0d (ptr %0d)", ack, pend, w, model_ptr);
          end else begin
            n_checks++;
            if (rf_write_addr !== addr_t[w] || rf_write_value !== val_t[w] || rf_write_select !== req_select[w]) begin
              n_fails++;
              $display("FAIL arb_payload: req %0d got addr=%h value=%h sel=%b, required %h %h %b",
                       w, rf_write_addr, rf_write_value, rf_write_select, addr_t[w], val_t[w], req_select[w]);
            end
            if (last >= 0) begin
              n_checks++;
              if (waited - last !== 4) begin
                n_fails++;
                $display("FAIL arb_spacing: %0d cycles between acks, required 4", waited - last);
              end
            end
            last = waited;
            pend[w] = 1'b0;
            req[w] = 1'b0;
            model_ptr = (w + 1) % NR;
          end
        end
      end
      n_checks++;
      if (pend !== '0) begin
        n_fails++;
        $display("FAIL arb_timeout: pending=%b after %0d cycles, required all served", pend, waited);
        req = '0;
      end
      repeat (3) @(negedge clk);
    end
  endtask

`ifdef REGFILE_CTRL_ROUND_ROBIN_EN
  task automatic test_rr_hold();
    int seq [5];
    int k = 0, waited = 0;
    seq = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      addr_t[i] = AW'(i + 10);
      val_t[i] = DW'($urandom);
    end
    req = '1;
    while (k < 5 && waited < 40) begin
      @(negedge clk);
      waited++;
      if (ack != '0) begin
        n_checks++;
        if (ack !== (NR'(1) << seq[k])) begin
          n_fails++;
          $display("FAIL rr_hold: ack #%0d=%b, required requester %0d", k, ack, seq[k]);
        end
        k++;
      end
    end
    n_checks++;
    if (k !== 5) begin
      n_fails++;
      $display("FAIL rr_hold_count: %0d acks seen, required 5", k);
    end
    req = '0;
    model_ptr = 1;
    repeat (4) @(negedge clk);
  endtask
`endif

  task automatic test_sync_vs_write();
    int waited = 0, sync_at = -1, done_at = -1, ack_at = -1;
    int s0, d0;
    bit early_wr = 1'b0;
    stub_dead = 1'b0;
    stub_len = 4;
    s0 = sync_pulses;
    d0 = done_pulses;
    addr_t[1] = AW'($urandom);
    val_t[1] = DW'($urandom);
    req[1] = 1'b1;
    sync_req = 1'b1;
    while (ack_at < 0 && waited < 60) begin
      @(negedge clk);
      waited++;
      sync_req = 1'b0;
      if (rf_sync && sync_at < 0) sync_at = waited;
      if (sync_at >= 0 && waited == sync_at + 1) sync_req = 1'b1;
      if (sync_done && done_at < 0) done_at = waited;
      if (rf_write_enable && done_at < 0) early_wr = 1'b1;
      if (ack != '0) ack_at = waited;
    end
    n_checks++;
    if (sync_at !== 2) begin
      n_fails++;
      $display("FAIL sync_first: rf_sync at cycle %0d, required 2", sync_at);
    end
    n_checks++;
    if (!(done_at > sync_at && ack_at > done_at) || early_wr) begin
      n_fails++;
      $display("FAIL sync_order: sync=%0d done=%0d ack=%0d early_wr=%b, required sync<done<ack",
               sync_at, done_at, ack_at, early_wr);
    end
    n_checks++;
    if (ack !== 4'b0010 || rf_write_addr !== addr_t[1] || rf_write_value !== val_t[1]) begin
      n_fails++;
      $display("FAIL sync_write: ack=%b addr=%h value=%h, required 0010 %h %h", ack, rf_write_addr, rf_write_value,
               addr_t[1], val_t[1]);
    end
    req[1] = 1'b0;
    model_ptr = 2;
    repeat (10) @(negedge clk);
    n_checks++;
    if (sync_pulses - s0 !== 1 || done_pulses - d0 !== 1 || sync_error !== 1'b0) begin
      n_fails++;
      $display("FAIL sync_merge: %0d syncs %0d dones err=%b, required 1 1 0", sync_pulses - s0, done_pulses - d0, sync_error);
    end
  endtask

  task automatic test_sync_zero();
    int waited = 0, done_at = -1, s0;
    n_active_blocks = '0;
    s0 = sync_pulses;
    sync_req = 1'b1;
    while (done_at < 0 && waited < 6) begin
      @(negedge clk);
      waited++;
      sync_req = 1'b0;
      if (sync_done) done_at = waited;
    end
    n_checks++;
    if (done_at < 1 || done_at > 2) begin
      n_fails++;
      $display("FAIL sync_zero_done: done at cycle %0d, required within 2", done_at);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (sync_pulses !== s0 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL sync_zero_nosync: %0d rf_sync pulses busy=%b, required 0 0", sync_pulses - s0, busy);
    end
    n_active_blocks = AW'(16);
  endtask

  task automatic test_sync_timeout();
    int waited = 0, sync_at = -1, done_at = -1;
    stub_dead = 1'b1;
    sync_req = 1'b1;
    while (done_at < 0 && waited < 30) begin
      @(negedge clk);
      waited++;
      sync_req = 1'b0;
      if (rf_sync && sync_at < 0) sync_at = waited;
      if (sync_done && done_at < 0) begin
        done_at = waited;
        n_checks++;
        if (sync_error !== 1'b1) begin
          n_fails++;
          $display("FAIL timeout_error: sync_error=%b with done, required 1", sync_error);
        end
      end
    end
    n_checks++;
    if (sync_at < 0 || done_at - sync_at !== TO) begin
      n_fails++;
      $display("FAIL timeout_delay: rf_sync at %0d done at %0d, required %0d apart", sync_at, done_at, TO);
    end
    stub_dead = 1'b0;
    sync_req = 1'b1;
    waited = 0;
    done_at = -1;
    while (done_at < 0 && waited < 30) begin
      @(negedge clk);
      waited++;
      sync_req = 1'b0;
      if (sync_done) done_at = waited;
    end
    n_checks++;
    if (done_at < 0 || sync_error !== 1'b1) begin
      n_fails++;
      $display("FAIL timeout_sticky: done_at=%0d sync_error=%b, required completed sync with error still 1",
               done_at, sync_error);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midwrite();
    int waited = 0;
    addr_t[3] = AW'($urandom);
    val_t[3] = DW'($urandom);
    req_select[3] = SEL_LO;
    req[3] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (ack !== 4'b1000) begin
      n_fails++;
      $display("FAIL midwrite_pre: ack=%b, required 1000 before reset", ack);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({ack, sync_done, sync_error, rf_write_enable, rf_sync, busy} !== '0 ||
        {rf_write_addr, rf_write_value, rf_write_select} !== '0) begin
      n_fails++;
      $display("FAIL midwrite_async: ack=%b err=%b we=%b busy=%b addr=%h value=%h, required all 0",
               ack, sync_error, rf_write_enable, busy, rf_write_addr, rf_write_value);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (ack == '0 && waited < 10);
    n_checks++;
    if (ack !== 4'b1000 || waited !== 2 || rf_write_addr !== addr_t[3] || rf_write_value !== val_t[3]) begin
      n_fails++;
      $display("FAIL midwrite_reserve: ack=%b after %0d addr=%h value=%h, required 1000 after 2 %h %h",
               ack, waited, rf_write_addr, rf_write_value, addr_t[3], val_t[3]);
    end
    req[3] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      addr_t[i] = '0;
      val_t[i] = '0;
    end
    test_reset();
    test_single_write();
    test_arbitration(5);
`ifdef REGFILE_CTRL_ROUND_ROBIN_EN
    test_rr_hold();
`endif
    test_sync_vs_write();
    test_sync_zero();
    test_sync_timeout();
    test_reset_midwrite();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
